mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu_pkg.sv | 27 ++
 rtl/mem_lsu_align.sv | 100 ++++++++++
 rtl/mem_lsu.sv | 183 ++++++++++++++++++
 tb/tb_mem_lsu.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the memory load/store unit: memop codes, FSM state
// encoding and bus widths.
package mem_lsu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int SEL_W  = 4;
    localparam int REG_W  = 5;
    localparam int OP_W   = 8;

    localparam logic [OP_W-1:0] ALUOP_NOP = 8'h00;
    localparam logic [OP_W-1:0] ALUOP_LB  = 8'h20;
    localparam logic [OP_W-1:0] ALUOP_LH  = 8'h21;
    localparam logic [OP_W-1:0] ALUOP_LW  = 8'h23;
    localparam logic [OP_W-1:0] ALUOP_LBU = 8'h24;
    localparam logic [OP_W-1:0] ALUOP_LHU = 8'h25;
    localparam logic [OP_W-1:0] ALUOP_SB  = 8'h28;
    localparam logic [OP_W-1:0] ALUOP_SH  = 8'h29;
    localparam logic [OP_W-1:0] ALUOP_SW  = 8'h2b;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/mem_lsu_align.sv
// lsu_align: purely combinational lane logic for the load/store unit.
// Decodes the memop, picks byte lanes, replicates store data and
// extends load data. Optional MEM_ALIGN_CHECK_EN adds a misalign flag.
module lsu_align
    import mem_lsu_pkg::*;
(
    input  logic [OP_W-1:0]   memop,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] reg2,
    input  logic [DATA_W-1:0] rdata,
    output logic              is_mem,
    output logic              is_load,
    output logic [SEL_W-1:0]  sel,
    output logic [DATA_W-1:0] st_data,
    output logic [DATA_W-1:0] ld_data
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic              misalign
`endif
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [3:0]  byte_sel;

    // Lane extraction from the read word and one-hot byte lane (little-endian).
    always_comb begin
        ld_byte  = rdata[7:0];
        byte_sel = 4'b0001;
        case (addr_lo)
            2'd0: begin ld_byte = rdata[7:0];   byte_sel = 4'b0001; end
            2'd1: begin ld_byte = rdata[15:8];  byte_sel = 4'b0010; end
            2'd2: begin ld_byte = rdata[23:16]; byte_sel = 4'b0100; end
            default: begin ld_byte = rdata[31:24]; byte_sel = 4'b1000; end
        endcase
        ld_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    end

    // Memop decode: class, lane select, store replication, load extension.
    always_comb begin
        is_mem  = 1'b1;
        is_load = 1'b0;
        sel     = '0;
        st_data = reg2;
        ld_data = rdata;
        case (memop)
            ALUOP_LB: begin
                is_load = 1'b1;
                sel     = byte_sel;
                ld_data = {{24{ld_byte[7]}}, ld_byte};
            end
            ALUOP_LBU: begin
                is_load = 1'b1;
                sel     = byte_sel;
                ld_data = {24'd0, ld_byte};
            end
            ALUOP_LH: begin
                is_load = 1'b1;
                sel     = addr_lo[1] ? 4'b1100 : 4'b0011;
                ld_data = {{16{ld_half[15]}}, ld_half};
            end
            ALUOP_LHU: begin
                is_load = 1'b1;
                sel     = addr_lo[1] ? 4'b1100 : 4'b0011;
                ld_data = {16'd0, ld_half};
            end
            ALUOP_LW: begin
                is_load = 1'b1;
                sel     = 4'b1111;
            end
            ALUOP_SB: begin
                sel     = byte_sel;
                st_data = {4{reg2[7:0]}};
            end
            ALUOP_SH: begin
                sel     = addr_lo[1] ? 4'b1100 : 4'b0011;
                st_data = {2{reg2[15:0]}};
            end
            ALUOP_SW: begin
                sel     = 4'b1111;
            end
            default: begin
                is_mem  = 1'b0;
            end
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    // Halfwords need an even address, words a 4-byte aligned one.
    always_comb begin
        misalign = 1'b0;
        case (memop)
            ALUOP_LH, ALUOP_LHU, ALUOP_SH: misalign = addr_lo[0];
            ALUOP_LW, ALUOP_SW:            misalign = |addr_lo;
            default:                       misalign = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit. Runs a three-state FSM
// (IDLE -> BUSY -> DONE) around a req/ack data bus and formats writeback.
// Optional feature macro: MEM_ALIGN_CHECK_EN (adds exc_adel/exc_ades and
// suppresses misaligned accesses).
//
// Bus handshake: dbus_req is raised on the edge entering BUSY together with
// registered dbus_we/sel/addr/wdata; all of them hold steady until the
// cycle in which the slave pulses dbus_ack (rdata valid in that same
// cycle). dbus_req drops on that edge. dbus_ack is ignored unless in BUSY.
module mem_lsu
    import mem_lsu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_W-1:0]  mem_wd,
    input  logic              mem_wreg,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [OP_W-1:0]   mem_memop,
    input  logic [ADDR_W-1:0] mem_maddr,
    input  logic [DATA_W-1:0] mem_reg2,
    input  logic              stall_in,
    output logic [REG_W-1:0]  wb_wd,
    output logic              wb_wreg,
    output logic [DATA_W-1:0] wb_wdata,
    output logic              stallreq_mem,
    output logic              dbus_req,
    output logic              dbus_we,
    output logic [SEL_W-1:0]  dbus_sel,
    output logic [ADDR_W-1:0] dbus_addr,
    output logic [DATA_W-1:0] dbus_wdata,
    input  logic              dbus_ack,
    input  logic [DATA_W-1:0] dbus_rdata,
`ifdef MEM_ALIGN_CHECK_EN
    output logic              exc_adel,
    output logic              exc_ades,
`endif
    output lsu_state_e        dbg_state
);

    lsu_state_e        state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] ld_buf_q, ld_buf_d;
    logic              load_q, load_d;
    logic              stall_c;

    logic              is_mem, is_load;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] st_data, ld_data;
    logic              bad_op;
    logic              mem_go;

`ifdef MEM_ALIGN_CHECK_EN
    logic misalign;
`endif

    lsu_align u_align (
        .memop   (mem_memop),
        .addr_lo (mem_maddr[1:0]),
        .reg2    (mem_reg2),
        .rdata   (dbus_rdata),
        .is_mem  (is_mem),
        .is_load (is_load),
        .sel     (sel),
        .st_data (st_data),
        .ld_data (ld_data)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .misalign(misalign)
`endif
    );

`ifdef MEM_ALIGN_CHECK_EN
    assign bad_op   = is_mem & misalign;
    assign exc_adel = bad_op & is_load;
    assign exc_ades = bad_op & ~is_load;
`else
    assign bad_op   = 1'b0;
`endif

    // A misaligned op (when checked) never touches the bus.
    assign mem_go    = is_mem & ~bad_op;
    assign dbg_state = state_q;

    // State and bus registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            sel_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ld_buf_q <= '0;
            load_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ld_buf_q <= ld_buf_d;
            load_q   <= load_d;
        end
    end

    // Next-state logic: launch in IDLE, wait for ack in BUSY, drain in DONE.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        sel_d    = sel_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ld_buf_d = ld_buf_q;
        load_d   = load_q;
        stall_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_go) begin
                    stall_c = 1'b1;
                    state_d = BUSY;
                    req_d   = 1'b1;
                    we_d    = ~is_load;
                    sel_d   = sel;
                    addr_d  = {mem_maddr[ADDR_W-1:2], 2'b00};
                    wdata_d = is_load ? '0 : st_data;
                    load_d  = is_load;
                end
            end
            BUSY: begin
                stall_c = 1'b1;
                if (dbus_ack) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    if (load_q) begin
                        ld_buf_d = ld_data;
                    end
                end
            end
            DONE: begin
                if (!stall_in) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Writeback mux: pass-through for non-memory ops, bubble while the access
    // is in flight, load buffer / ALU result once DONE; zeroed in reset.
    always_comb begin
        wb_wd        = mem_wd;
        wb_wreg      = mem_wreg;
        wb_wdata     = mem_wdata;
        stallreq_mem = stall_c;
        if (state_q == DONE) begin
            wb_wreg  = load_q & mem_wreg;
            wb_wdata = load_q ? ld_buf_q : mem_wdata;
        end else if (state_q == BUSY || mem_go || bad_op) begin
            wb_wreg  = 1'b0;
        end
        if (!rst) begin
            wb_wd        = '0;
            wb_wreg      = 1'b0;
            wb_wdata     = '0;
            stallreq_mem = 1'b0;
        end
    end

    assign dbus_req   = req_q;
    assign dbus_we    = we_q;
    assign dbus_sel   = sel_q;
    assign dbus_addr  = addr_q;
    assign dbus_wdata = wdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Testbench for mem_lsu: table-driven accesses with a writeback scoreboard,
// plus hand-written sequences for delayed ack, DONE hold, reset in BUSY,
// stray ack, pass-through and (with MEM_ALIGN_CHECK_EN) misalignment.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    logic        clk;
    logic        rst;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_memop;
    logic [31:0] mem_maddr;
    logic [31:0] mem_reg2;
    logic        stall_in;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        stallreq_mem;
    logic        dbus_req;
    logic        dbus_we;
    logic [3:0]  dbus_sel;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;
`ifdef MEM_ALIGN_CHECK_EN
    logic        exc_adel;
    logic        exc_ades;
`endif
    lsu_state_e  dbg_state;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_wreg_q[$];

    mem_lsu dut (
        .clk         (clk),
        .rst         (rst),
        .mem_wd      (mem_wd),
        .mem_wreg    (mem_wreg),
        .mem_wdata   (mem_wdata),
        .mem_memop   (mem_memop),
        .mem_maddr   (mem_maddr),
        .mem_reg2    (mem_reg2),
        .stall_in    (stall_in),
        .wb_wd       (wb_wd),
        .wb_wreg     (wb_wreg),
        .wb_wdata    (wb_wdata),
        .stallreq_mem(stallreq_mem),
        .dbus_req    (dbus_req),
        .dbus_we     (dbus_we),
        .dbus_sel    (dbus_sel),
        .dbus_addr   (dbus_addr),
        .dbus_wdata  (dbus_wdata),
        .dbus_ack    (dbus_ack),
        .dbus_rdata  (dbus_rdata),
`ifdef MEM_ALIGN_CHECK_EN
        .exc_adel    (exc_adel),
        .exc_ades    (exc_ades),
`endif
        .dbg_state   (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit is_store_op(input logic [7:0] op);
        return (op == ALUOP_SB) || (op == ALUOP_SH) || (op == ALUOP_SW);
    endfunction

    function automatic bit is_mem_op(input logic [7:0] op);
        return is_store_op(op) || (op == ALUOP_LB) || (op == ALUOP_LBU) ||
               (op == ALUOP_LH) || (op == ALUOP_LHU) || (op == ALUOP_LW);
    endfunction

    // Driver: issue one access (called just after a rising edge with the DUT
    // in IDLE), ack on the ack_at-th BUSY cycle, check writeback in DONE.
    task automatic do_access(input logic [7:0] op, input logic [31:0] addr,
                             input logic [31:0] reg2, input logic [31:0] rdata,
                             input logic [31:0] exp_ld, input int ack_at,
                             output logic [3:0] sel0, output logic we0,
                             output logic [31:0] addr0, output logic [31:0] wd0,
                             output int stall_n, output int busy_n);
        bit done;
        mem_memop = op;
        mem_maddr = addr;
        mem_reg2  = reg2;
        mem_wd    = 5'($urandom_range(1, 31));
        mem_wreg  = 1'b1;
        mem_wdata = $urandom;
        if (is_store_op(op)) begin
            exp_q.push_back(mem_wdata);
            exp_wreg_q.push_back(32'd0);
        end else begin
            exp_q.push_back(exp_ld);
            exp_wreg_q.push_back(32'd1);
        end
        stall_n = 0;
        busy_n  = 0;
        done    = 1'b0;
        sel0    = '0;
        we0     = 1'b0;
        addr0   = '0;
        wd0     = '0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            if (stallreq_mem) stall_n++;
            if (dbus_req) begin
                busy_n++;
                if (busy_n == 1) begin
                    sel0  = dbus_sel;
                    we0   = dbus_we;
                    addr0 = dbus_addr;
                    wd0   = dbus_wdata;
                end else begin
                    check("bus_addr_stable", dbus_addr, addr0);
                    check("bus_sel_stable", 32'(dbus_sel), 32'(sel0));
                    check("bus_we_stable", 32'(dbus_we), 32'(we0));
                    check("bus_wdata_stable", dbus_wdata, wd0);
                end
                if (busy_n >= ack_at) begin
                    dbus_ack   = 1'b1;
                    dbus_rdata = rdata;
                end
            end else if (!stallreq_mem) begin
                done = 1'b1;
                if (exp_q.size() > 0) begin
                    check("wb_wdata", wb_wdata, exp_q.pop_front());
                    check("wb_wreg", 32'(wb_wreg), exp_wreg_q.pop_front());
                    check("wb_wd", 32'(wb_wd), 32'(mem_wd));
                end
            end
            @(posedge clk);
            #1;
            dbus_ack   = 1'b0;
            dbus_rdata = $urandom;
        end
        mem_memop = ALUOP_NOP;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL access_timeout: op %h got no DONE within 40 cycles", op);
        end
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] reg2;
        logic [31:0] rdata;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] bus_wd;
        logic [31:0] ld;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    initial begin
        logic [3:0]  sel0;
        logic        we0;
        logic [31:0] addr0, wd0;
        int          stall_n, busy_n;

        rst        = 1'b0;
        stall_in   = 1'b0;
        dbus_ack   = 1'b0;
        dbus_rdata = '0;
        mem_memop  = ALUOP_LW;
        mem_maddr  = 32'h100;
        mem_reg2   = 32'h0;
        mem_wd     = 5'd3;
        mem_wreg   = 1'b1;
        mem_wdata  = 32'h1234;

        // Reset state, with a memory op present on the inputs
        repeat (2) @(negedge clk);
        check("rst_dbus_req", 32'(dbus_req), 32'd0);
        check("rst_dbus_we", 32'(dbus_we), 32'd0);
        check("rst_dbus_sel", 32'(dbus_sel), 32'd0);
        check("rst_dbus_addr", dbus_addr, 32'd0);
        check("rst_dbus_wdata", dbus_wdata, 32'd0);
        check("rst_stallreq", 32'(stallreq_mem), 32'd0);
        check("rst_wb_wd", 32'(wb_wd), 32'd0);
        check("rst_wb_wreg", 32'(wb_wreg), 32'd0);
        check("rst_wb_wdata", wb_wdata, 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        mem_memop = ALUOP_NOP;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven accesses, ack on the first BUSY cycle
        vecs[0] = '{ALUOP_LW,  32'h100, 32'h0,        32'hDEADBEEF, 4'b1111, 1'b0, 32'h0,        32'hDEADBEEF};
        vecs[1] = '{ALUOP_LB,  32'h103, 32'h0,        32'h80112233, 4'b1000, 1'b0, 32'h0,        32'hFFFFFF80};
        vecs[2] = '{ALUOP_LBU, 32'h103, 32'h0,        32'h80112233, 4'b1000, 1'b0, 32'h0,        32'h00000080};
        vecs[3] = '{ALUOP_SH,  32'h202, 32'h0000ABCD, 32'h0,        4'b1100, 1'b1, 32'hABCDABCD, 32'h0};
        vecs[4] = '{ALUOP_LH,  32'h102, 32'h0,        32'h80017FFF, 4'b1100, 1'b0, 32'h0,        32'hFFFF8001};
        vecs[5] = '{ALUOP_LHU, 32'h100, 32'h0,        32'h12349ABC, 4'b0011, 1'b0, 32'h0,        32'h00009ABC};
        vecs[6] = '{ALUOP_LB,  32'h101, 32'h0,        32'h00007F00, 4'b0010, 1'b0, 32'h0,        32'h0000007F};
        vecs[7] = '{ALUOP_SB,  32'h305, 32'h123456EF, 32'h0,        4'b0010, 1'b1, 32'hEFEFEFEF, 32'h0};
        vecs[8] = '{ALUOP_SW,  32'h400, 32'hCAFEF00D, 32'h0,        4'b1111, 1'b1, 32'hCAFEF00D, 32'h0};
        vecs[9] = '{ALUOP_LBU, 32'h102, 32'h0,        32'h00AB0000, 4'b0100, 1'b0, 32'h0,        32'h000000AB};

        for (int i = 0; i < NV; i++) begin
            do_access(vecs[i].op, vecs[i].addr, vecs[i].reg2, vecs[i].rdata, vecs[i].ld, 1,
                      sel0, we0, addr0, wd0, stall_n, busy_n);
            check($sformatf("v%0d_sel", i), 32'(sel0), 32'(vecs[i].sel));
            check($sformatf("v%0d_we", i), 32'(we0), 32'(vecs[i].we));
            check($sformatf("v%0d_addr", i), addr0, vecs[i].addr & 32'hFFFF_FFFC);
            if (vecs[i].we) check($sformatf("v%0d_bus_wdata", i), wd0, vecs[i].bus_wd);
            check($sformatf("v%0d_stall_cycles", i), 32'(stall_n), 32'd2);
            check($sformatf("v%0d_busy_cycles", i), 32'(busy_n), 32'd1);
        end

        // Ack on the 5th BUSY cycle: stall spans IDLE plus five BUSY cycles
        do_access(ALUOP_LW, 32'h100, 32'h0, 32'h13579BDF, 32'h13579BDF, 5,
                  sel0, we0, addr0, wd0, stall_n, busy_n);
        check("slow_stall_cycles", 32'(stall_n), 32'd6);
        check("slow_busy_cycles", 32'(busy_n), 32'd5);
        check("slow_addr", addr0, 32'h100);

        // DONE holds while stall_in is high
        stall_in = 1'b1;
        do_access(ALUOP_LHU, 32'h102, 32'h0, 32'hABCD0000, 32'h0000ABCD, 2,
                  sel0, we0, addr0, wd0, stall_n, busy_n);
        @(negedge clk);
        check("hold_state", 32'(dbg_state), 32'(DONE));
        check("hold_stallreq", 32'(stallreq_mem), 32'd0);
        check("hold_wb_wdata", wb_wdata, 32'h0000ABCD);
        stall_in = 1'b0;
        @(negedge clk);
        check("release_state", 32'(dbg_state), 32'(IDLE));
        @(posedge clk);
        #1;

        // Non-memory ops pass straight through; a stray ack in IDLE is ignored
        for (int i = 0; i < 6; i++) begin
            mem_memop = 8'($urandom_range(0, 255));
            if (is_mem_op(mem_memop)) mem_memop = ALUOP_NOP;
            mem_wd    = 5'($urandom_range(0, 31));
            mem_wreg  = 1'($urandom_range(0, 1));
            mem_wdata = $urandom;
            mem_maddr = $urandom;
            dbus_ack  = (i == 2);
            @(negedge clk);
            check("pass_wb_wd", 32'(wb_wd), 32'(mem_wd));
            check("pass_wb_wreg", 32'(wb_wreg), 32'(mem_wreg));
            check("pass_wb_wdata", wb_wdata, mem_wdata);
            check("pass_stallreq", 32'(stallreq_mem), 32'd0);
            check("pass_dbus_req", 32'(dbus_req), 32'd0);
            @(posedge clk);
            #1;
            dbus_ack = 1'b0;
        end
        check("stray_ack_state", 32'(dbg_state), 32'(IDLE));

        // Reset asserted while BUSY
        mem_memop = ALUOP_SW;
        mem_maddr = 32'h500;
        mem_reg2  = $urandom;
        mem_wreg  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_busy_req", 32'(dbus_req), 32'd1);
        rst = 1'b0;
        #1;
        check("busy_rst_req", 32'(dbus_req), 32'd0);
        check("busy_rst_we", 32'(dbus_we), 32'd0);
        check("busy_rst_sel", 32'(dbus_sel), 32'd0);
        check("busy_rst_addr", dbus_addr, 32'd0);
        check("busy_rst_wdata", dbus_wdata, 32'd0);
        check("busy_rst_stallreq", 32'(stallreq_mem), 32'd0);
        check("busy_rst_state", 32'(dbg_state), 32'(IDLE));
        mem_memop = ALUOP_NOP;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        dbus_ack   = 1'b1;
        dbus_rdata = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        dbus_ack = 1'b0;
        @(negedge clk);
        check("late_ack_state", 32'(dbg_state), 32'(IDLE));
        check("late_ack_req", 32'(dbus_req), 32'd0);
        check("late_ack_stallreq", 32'(stallreq_mem), 32'd0);
        @(posedge clk);
        #1;

        // A normal access still completes after that
        do_access(ALUOP_LH, 32'h100, 32'h0, 32'h0000F00F, 32'hFFFFF00F, 1,
                  sel0, we0, addr0, wd0, stall_n, busy_n);
        check("post_rst_sel", 32'(sel0), 32'h3);

`ifdef MEM_ALIGN_CHECK_EN
        // Misaligned word load / store: flagged, no bus request, no stall
        mem_memop = ALUOP_LW;
        mem_maddr = 32'h101;
        mem_wreg  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("adel_flag", 32'(exc_adel), 32'd1);
            check("adel_ades", 32'(exc_ades), 32'd0);
            check("adel_req", 32'(dbus_req), 32'd0);
            check("adel_stallreq", 32'(stallreq_mem), 32'd0);
            check("adel_wb_wreg", 32'(wb_wreg), 32'd0);
            @(posedge clk);
            #1;
        end
        mem_memop = ALUOP_SW;
        mem_maddr = 32'h102;
        @(negedge clk);
        check("ades_flag", 32'(exc_ades), 32'd1);
        check("ades_adel", 32'(exc_adel), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("ades_req", 32'(dbus_req), 32'd0);
        @(posedge clk);
        #1;
        mem_memop = ALUOP_NOP;
`else
        // Misaligned halfword proceeds; only maddr[1] picks the lanes
        do_access(ALUOP_LH, 32'h101, 32'h0, 32'h0000FFFE, 32'hFFFFFFFE, 1,
                  sel0, we0, addr0, wd0, stall_n, busy_n);
        check("misalign_sel", 32'(sel0), 32'h3);
        check("misalign_addr", addr0, 32'h100);
        check("misalign_stall", 32'(stall_n), 32'd2);
`endif

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
